// File: rtl/dist_ram_arb.sv
// dist_ram_arb: two-requester round-robin front end for a distributed RAM
// with one write/shared port and an asynchronous read output (ram_spo).
// Requests accepted in cycle T drive the RAM port in T+1. Read data is
// returned on the originating requester's response port in T+2.
// Optional build macro DIST_RAM_ARB_CLEAR_EN adds a post-reset CLEAR walk
// that writes zero to every RAM address before requests are accepted.
module dist_ram_arb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_spo,
  output logic                  busy
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  logic clr;

`ifdef DIST_RAM_ARB_CLEAR_EN
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and clear-address counter registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk the counter through every address; the last address ends CLEAR
  // so the natural wrap to zero never restarts the walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = RUN;
    end
  end

  assign clr = (state_q == CLEAR);
`else
  assign clr = 1'b0;
`endif

  assign busy = clr;

  // ptr_q = last served requester; reset to 1 so req0 wins the first tie.
  logic ptr_q;
  logic acc0, acc1;

  // Ready only looks at the other side's valid: a requester is blocked only
  // when the other one is also asking and it was not served last.
  assign req0_ready = !clr && (!req1_valid || ptr_q);
  assign req1_ready = !clr && (!req0_valid || !ptr_q);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  // Last-served pointer follows each accept, holds otherwise
  always_ff @(posedge clk or posedge RST) begin
    if (RST)       ptr_q <= 1'b1;
    else if (acc0) ptr_q <= 1'b0;
    else if (acc1) ptr_q <= 1'b1;
  end

  // Access stage: drives the RAM port one cycle after accept.
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic                  rd_q, rd_d;
  logic                  id_q, id_d;

  // Select what the access stage holds next: clear write, accepted request,
  // or nothing (address/data hold, write strobe drops)
  always_comb begin
    we_d = 1'b0;
    a_d  = a_q;
    di_d = di_q;
    rd_d = 1'b0;
    id_d = id_q;
`ifdef DIST_RAM_ARB_CLEAR_EN
    if (clr) begin
      we_d = 1'b1;
      a_d  = cnt_q;
      di_d = '0;
    end else
`endif
    if (acc0) begin
      we_d = req0_we;
      a_d  = req0_addr;
      di_d = req0_wdata;
      rd_d = !req0_we;
      id_d = 1'b0;
    end else if (acc1) begin
      we_d = req1_we;
      a_d  = req1_addr;
      di_d = req1_wdata;
      rd_d = !req1_we;
      id_d = 1'b1;
    end
  end

  // Access stage registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      we_q <= 1'b0;
      a_q  <= '0;
      di_q <= '0;
      rd_q <= 1'b0;
      id_q <= 1'b0;
    end else begin
      we_q <= we_d;
      a_q  <= a_d;
      di_q <= di_d;
      rd_q <= rd_d;
      id_q <= id_d;
    end
  end

  assign ram_we = we_q;
  assign ram_a  = a_q;
  assign ram_di = di_q;

  // Response stage: capture the asynchronous RAM read at the end of the
  // access cycle and pulse the originating requester's response port.
  logic [1:0]            rsp_vld_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  // Response valid pulses and read-data capture
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rsp_vld_q <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rsp_vld_q[0] <= rd_q && !id_q;
      rsp_vld_q[1] <= rd_q && id_q;
      if (rd_q && !id_q) rdata0_q <= ram_spo;
      if (rd_q && id_q)  rdata1_q <= ram_spo;
    end
  end

  assign rsp0_valid = rsp_vld_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;

endmodule

// File: tb/tb_dist_ram_arb.sv
// Self-checking bench for dist_ram_arb: a behavioural RAM sits on the RAM
// port, and a reference model (shadow memory + expected-response queue +
// last-served requester) predicts ready, RAM drive and responses.
module tb_dist_ram_arb;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk, RST;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_spo;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t pq[$];
  bit   ptr_m;

`ifdef DIST_RAM_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  dist_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .RST(RST),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_spo(ram_spo),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural distributed RAM: synchronous write, asynchronous read
  assign ram_spo = mem[ram_a];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if (ram_we !== 1'b0 || ram_a !== '0 || ram_di !== '0) begin
      errors++;
      $display("FAIL reset_ram got we=%b a=%h di=%h exp we=0 a=0 di=0", ram_we, ram_a, ram_di);
    end
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rsp got v0=%b v1=%b d0=%h d1=%h exp all 0", rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
    end
    checks++;
    if (busy !== CLR_EN) begin
      errors++;
      $display("FAIL reset_busy got %b exp %b", busy, CLR_EN);
    end
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    ptr_m = 1'b1;
    pq.delete();
  endtask

  // Clear walk: busy for DEPTH cycles, zero written to ascending addresses
  // one cycle behind the counter (through the access stage).
  task automatic test_clear();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_busy k=%0d got busy=%b r0=%b r1=%b exp busy=1 r0=0 r1=0", k, busy, req0_ready, req1_ready);
      end
      if (k >= 1) begin
        checks++;
        if (ram_we !== 1'b1 || ram_a !== AW'(k - 1) || ram_di !== '0) begin
          errors++;
          $display("FAIL clear_write k=%0d got we=%b a=%0d di=%h exp we=1 a=%0d di=0", k, ram_we, ram_a, ram_di, k - 1);
        end
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Read of the top address in the first cycle requests are allowed
  task automatic test_first_read();
    int t;
    logic [DW-1:0] exp_d;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = AW'(DEPTH - 1);
    exp_d = ref_mem[DEPTH - 1];
    @(negedge clk);
    t = cyc;
    checks++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_ready got r0=%b busy=%b exp r0=1 busy=0", req0_ready, busy);
    end
    if (CLR_EN) begin
      checks++;
      if (ram_we !== 1'b1 || ram_a !== AW'(DEPTH - 1)) begin
        errors++;
        $display("FAIL clear_last got we=%b a=%0d exp we=1 a=%0d", ram_we, ram_a, DEPTH - 1);
      end
    end
    ptr_m = 1'b0;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || ram_a !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL first_stage got v0=%b a=%0d exp v0=0 a=%0d", rsp0_valid, ram_a, DEPTH - 1);
    end
    @(negedge clk);
    checks++;
    if (cyc != t + 2 || rsp0_valid !== 1'b1 || rsp0_rdata !== exp_d || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_rsp got v0=%b d=%h v1=%b exp v0=1 d=%h v1=0", rsp0_valid, rsp0_rdata, rsp1_valid, exp_d);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_pulse got v0=%b exp 0", rsp0_valid);
    end
  endtask

  // Write A5A5 to address 5, read it back the very next cycle
  task automatic test_write_read();
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd5; req0_wdata = 16'hA5A5;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready got %b exp 1", req0_ready);
    end
    @(posedge clk);
    #1;
    req0_we = 1'b0; req0_wdata = 16'h0000;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_a !== 6'd5 || ram_di !== 16'hA5A5 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_stage got we=%b a=%0d di=%h r0=%b exp we=1 a=5 di=a5a5 r0=1", ram_we, ram_a, ram_di, req0_ready);
    end
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_a !== 6'd5 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_stage got we=%b a=%0d v0=%b v1=%b exp we=0 a=5 v0=0 v1=0", ram_we, ram_a, rsp0_valid, rsp1_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 16'hA5A5 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_rsp got v0=%b d=%h v1=%b exp v0=1 d=a5a5 v1=0", rsp0_valid, rsp0_rdata, rsp1_valid);
    end
    ref_mem[5] = 16'hA5A5;
    ptr_m = 1'b0;
  endtask

  // Traffic against the reference model. pat 0: random both sides,
  // pat 1: both always valid reading, pat 2: only req1 valid.
  // Four idle cycles at the end drain outstanding responses.
  task automatic test_traffic(input int n, input int pat);
    bit            ew_m, ew_n, er0, er1, ev0, ev1, a0, a1;
    logic [AW-1:0] ea_m;
    logic [DW-1:0] ed_m, ed;
    int            acc_cnt;
    rsp_t          e;
    ew_m = 1'b0; ea_m = '0; ed_m = '0; acc_cnt = 0;
    for (int i = 0; i < n + 4; i++) begin
      @(posedge clk);
      #1;
      idle_inputs();
      if (i < n) begin
        req0_addr = AW'($urandom); req0_wdata = DW'($urandom);
        req1_addr = AW'($urandom); req1_wdata = DW'($urandom);
        case (pat)
          0: begin
            req0_valid = 1'($urandom_range(1, 0)); req0_we = 1'($urandom_range(1, 0));
            req1_valid = 1'($urandom_range(1, 0)); req1_we = 1'($urandom_range(1, 0));
          end
          1: begin req0_valid = 1'b1; req1_valid = 1'b1; end
          default: begin req1_valid = 1'b1; req1_we = 1'($urandom_range(1, 0)); end
        endcase
      end
      @(negedge clk);
      er0 = !req1_valid || ptr_m;
      er1 = !req0_valid || !ptr_m;
      checks++;
      if (req0_ready !== er0 || req1_ready !== er1) begin
        errors++;
        $display("FAIL ready cyc=%0d got r0=%b r1=%b exp r0=%b r1=%b", cyc, req0_ready, req1_ready, er0, er1);
      end
      ev0 = 1'b0; ev1 = 1'b0; ed = '0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e = pq.pop_front();
        ev0 = !e.id; ev1 = e.id; ed = e.data;
      end
      checks++;
      if (rsp0_valid !== ev0 || rsp1_valid !== ev1) begin
        errors++;
        $display("FAIL rsp_valid cyc=%0d got v0=%b v1=%b exp v0=%b v1=%b", cyc, rsp0_valid, rsp1_valid, ev0, ev1);
      end
      if (ev0 || ev1) begin
        checks++;
        if ((ev0 ? rsp0_rdata : rsp1_rdata) !== ed) begin
          errors++;
          $display("FAIL rsp_data cyc=%0d got %h exp %h", cyc, ev0 ? rsp0_rdata : rsp1_rdata, ed);
        end
      end
      checks++;
      if (ram_we !== ew_m || (ew_m && (ram_a !== ea_m || ram_di !== ed_m))) begin
        errors++;
        $display("FAIL ram_drive cyc=%0d got we=%b a=%0d di=%h exp we=%b a=%0d di=%h", cyc, ram_we, ram_a, ram_di, ew_m, ea_m, ed_m);
      end
      a0 = req0_valid && er0;
      a1 = req1_valid && er1;
      ew_n = 1'b0;
      if (a0 || a1) begin
        acc_cnt++;
        ptr_m = a1;
        if (a0 ? req0_we : req1_we) begin
          ew_n = 1'b1;
          ea_m = a0 ? req0_addr : req1_addr;
          ed_m = a0 ? req0_wdata : req1_wdata;
          ref_mem[ea_m] = ed_m;
        end else begin
          pq.push_back('{due: cyc + 2, id: a1, data: ref_mem[a0 ? req0_addr : req1_addr]});
        end
      end
      ew_m = ew_n;
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL rsp_drain got %0d pending exp 0", pq.size());
      pq.delete();
    end
    if (pat == 2) begin
      checks++;
      if (acc_cnt != n || ptr_m !== 1'b1) begin
        errors++;
        $display("FAIL req1_only got accepts=%0d exp %0d", acc_cnt, n);
      end
    end
  endtask

  // Reset right after a read is accepted: its response must never appear
  task automatic test_reset_drop();
    int wait_n;
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd7;
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready got %b exp 1", req0_ready);
    end
    @(posedge clk);
    #2;
    RST = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_a !== '0 || ram_di !== '0 || rsp0_valid !== 1'b0 ||
        rsp1_valid !== 1'b0 || rsp0_rdata !== '0 || rsp1_rdata !== '0 || busy !== CLR_EN) begin
      errors++;
      $display("FAIL drop_reset_vals got we=%b a=%0d di=%h v0=%b v1=%b d0=%h d1=%h busy=%b", ram_we, ram_a, ram_di, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_in_reset got v0=%b v1=%b exp 0 0", rsp0_valid, rsp1_valid);
    end
    @(posedge clk);
    #1 RST = 1'b0;
    ptr_m = 1'b1;
    pq.delete();
    wait_n = CLR_EN ? DEPTH + 2 : 4;
    for (int k = 0; k < wait_n; k++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_after got v0=%b v1=%b exp 0 0", rsp0_valid, rsp1_valid);
      end
      @(posedge clk);
      #1;
    end
    if (CLR_EN) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    if (CLR_EN) test_clear();
    test_first_read();
    test_write_read();
    test_traffic(8, 1);
    test_traffic(4, 2);
    test_traffic(8, 1);
    test_traffic(300, 0);
    test_reset_drop();
    test_traffic(8, 1);
    test_traffic(150, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
